// File: rtl/tea_pkg.sv
// Shared types, constants and helpers for the TEA cipher core.
// Optional build macro used by the core: TEA_UNROLL2_EN (two rounds per clock).
package tea_pkg;

  localparam logic [31:0] DELTA_DEFAULT = 32'h9E3779B9;

  // Word positions of k0..k3 inside the 128-bit key (k0 is the top word).
  localparam int K0_IDX = 3;
  localparam int K1_IDX = 2;
  localparam int K2_IDX = 1;
  localparam int K3_IDX = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_e;

  function automatic logic [31:0] key_word(input logic [127:0] key, input int idx);
    return key[idx*32 +: 32];
  endfunction

  // Decrypt walks the schedule backwards, so it starts from DELTA*ROUNDS.
  function automatic logic [31:0] tea_sum_init(input logic mode, input int rounds,
                                               input logic [31:0] delta);
    logic [31:0] rounds_w;
    rounds_w = 32'(rounds);
    return mode ? delta * rounds_w : 32'h0;
  endfunction

  function automatic logic [31:0] tea_mix(input logic [31:0] x, input logic [31:0] sum,
                                          input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + sum) ^ ((x >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA cycle (both halves), encrypt or decrypt, purely combinational.
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = DELTA_DEFAULT
) (
  input  logic         mode_i,
  input  logic [31:0]  v0_i,
  input  logic [31:0]  v1_i,
  input  logic [31:0]  sum_i,
  input  logic [127:0] key_i,
  output logic [31:0]  v0_o,
  output logic [31:0]  v1_o,
  output logic [31:0]  sum_o
);

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] enc_sum, enc_v0, enc_v1;
  logic [31:0] dec_v0, dec_v1;

  assign k0 = key_word(key_i, K0_IDX);
  assign k1 = key_word(key_i, K1_IDX);
  assign k2 = key_word(key_i, K2_IDX);
  assign k3 = key_word(key_i, K3_IDX);

  // Second half of each direction depends on the freshly updated first half.
  always_comb begin
    enc_sum = sum_i + DELTA;
    enc_v0  = v0_i + tea_mix(v1_i, enc_sum, k0, k1);
    enc_v1  = v1_i + tea_mix(enc_v0, enc_sum, k2, k3);
    dec_v1  = v1_i - tea_mix(v0_i, sum_i, k2, k3);
    dec_v0  = v0_i - tea_mix(dec_v1, sum_i, k0, k1);
  end

  assign v0_o  = mode_i ? dec_v0 : enc_v0;
  assign v1_o  = mode_i ? dec_v1 : enc_v1;
  assign sum_o = mode_i ? (sum_i - DELTA) : enc_sum;

endmodule

// File: rtl/tea_cipher_core.sv
// Iterative TEA core: accepts one block, runs ROUNDS cycles, presents the result.
// Define TEA_UNROLL2_EN to chain two rounds per clock (ROUNDS must then be even).
module tea_cipher_core
  import tea_pkg::*;
#(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = DELTA_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [31:0]  in_v0,
  input  logic [31:0]  in_v1,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_v0,
  output logic [31:0]  out_v1,
  output logic         busy
);

`ifdef TEA_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [6:0] LAST_CNT = 7'(ROUNDS - STEP);

  if (ROUNDS < 1 || ROUNDS > 64) begin : g_bad_rounds
    $error("tea_cipher_core: ROUNDS must be in 1..64");
  end
`ifdef TEA_UNROLL2_EN
  if (ROUNDS % 2 != 0) begin : g_odd_rounds
    $error("tea_cipher_core: ROUNDS must be even when two rounds run per clock");
  end
`endif

  tea_state_e   state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [31:0]  v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [127:0] key_q, key_d;
  logic         mode_q, mode_d;
  logic [31:0]  out_v0_q, out_v0_d, out_v1_q, out_v1_d;

  logic [31:0]  r1_v0, r1_v1, r1_sum;
  logic [31:0]  nx_v0, nx_v1, nx_sum;

  tea_round #(.DELTA(DELTA)) u_round0 (
    .mode_i (mode_q),
    .v0_i   (v0_q),
    .v1_i   (v1_q),
    .sum_i  (sum_q),
    .key_i  (key_q),
    .v0_o   (r1_v0),
    .v1_o   (r1_v1),
    .sum_o  (r1_sum)
  );

`ifdef TEA_UNROLL2_EN
  tea_round #(.DELTA(DELTA)) u_round1 (
    .mode_i (mode_q),
    .v0_i   (r1_v0),
    .v1_i   (r1_v1),
    .sum_i  (r1_sum),
    .key_i  (key_q),
    .v0_o   (nx_v0),
    .v1_o   (nx_v1),
    .sum_o  (nx_sum)
  );
`else
  assign nx_v0  = r1_v0;
  assign nx_v1  = r1_v1;
  assign nx_sum = r1_sum;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    sum_d    = sum_q;
    key_d    = key_q;
    mode_d   = mode_q;
    out_v0_d = out_v0_q;
    out_v1_d = out_v1_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          v0_d    = in_v0;
          v1_d    = in_v1;
          key_d   = in_key;
          mode_d  = in_mode;
          sum_d   = tea_sum_init(in_mode, ROUNDS, DELTA);
          cnt_d   = 7'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        v0_d  = nx_v0;
        v1_d  = nx_v1;
        sum_d = nx_sum;
        cnt_d = cnt_q + 7'(STEP);
        if (cnt_q == LAST_CNT) begin
          out_v0_d = nx_v0;
          out_v1_d = nx_v1;
          cnt_d    = 7'd0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      v0_q     <= 32'h0;
      v1_q     <= 32'h0;
      sum_q    <= 32'h0;
      key_q    <= 128'h0;
      mode_q   <= 1'b0;
      out_v0_q <= 32'h0;
      out_v1_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      sum_q    <= sum_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      out_v0_q <= out_v0_d;
      out_v1_q <= out_v1_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_v0    = out_v0_q;
  assign out_v1    = out_v1_q;

endmodule
